// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - shared two-port data-memory responder with round-robin arbitration and fixed latency
//
// Purpose: serves word read/write requests from two L1 caches. Requests are
// serialized: IDLE arbitrates, ACCESS models LATENCY cycles, RESP pulses ack.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   pX_rd_en, pX_wr_en   level-held request from port X (both high = write)
//   pX_addr, pX_wdata    word address and full-word write data
//   pX_rdata             read data, held until the next completed read on port X
//   pX_ack               one-cycle completion pulse to port X
//   busy                 high whenever the responder is not in IDLE

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_rd_en,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic [31:0]       p0_rdata,
    output logic              p0_ack,
    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic [31:0]       p1_rdata,
    output logic              p1_ack,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rr;
    logic              r_port;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_req0;
    logic              w_req1;
    logic              w_grant_port;
    logic              w_grant_wr;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [31:0]       w_grant_wdata;
    logic              w_do_access;
    logic [31:0]       w_mem_rdata;

    assign w_req0 = p0_rd_en | p0_wr_en;
    assign w_req1 = p1_rd_en | p1_wr_en;

    // Contention goes to rr; otherwise the lone requester wins (port 1 only
    // when port 0 is silent).
    assign w_grant_port  = (w_req0 && w_req1) ? r_rr : w_req1;
    assign w_grant_wr    = w_grant_port ? p1_wr_en : p0_wr_en;
    assign w_grant_addr  = w_grant_port ? p1_addr  : p0_addr;
    assign w_grant_wdata = w_grant_port ? p1_wdata : p0_wdata;

    assign w_do_access = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_mem_rdata = r_mem[r_addr];

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_rr     <= 1'b0;
            r_port   <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= 32'd0;
            p1_rdata <= 32'd0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_port  <= w_grant_port;
                        r_wr    <= w_grant_wr;
                        r_addr  <= w_grant_addr;
                        r_wdata <= w_grant_wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_wr) begin
                            if (r_port) p1_rdata <= w_mem_rdata;
                            else        p0_rdata <= w_mem_rdata;
                        end
                        // ack is registered here so it is high during RESP
                        if (r_port) p1_ack <= 1'b1;
                        else        p0_ack <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_rr    <= ~r_port;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else if (w_do_access && r_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
